// File: rtl/fetch_buffer_pkg.sv
// Shared types and helpers for the fetch buffer.
// fb_entry_t is the default {pc, inst} entry at 32-bit width. Instances with
// other widths build their own entry type of the same shape.
package fetch_buffer_pkg;

  localparam int FB_WIDTH = 32;

  typedef struct packed {
    logic [FB_WIDTH-1:0] pc;
    logic [FB_WIDTH-1:0] inst;
  } fb_entry_t;

  // Unsigned minimum, used for the avail/take clamps.
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// Entry storage for the fetch buffer.
// DEPTH x entry_t register array with FETCH_W write ports and ISSUE_W
// asynchronous read ports. Contents are never reset; the top level only
// exposes entries that its head/count say are live.
module fetch_buffer_ram
  import fetch_buffer_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter int  FETCH_W = 2,
  parameter int  ISSUE_W = 2,
  parameter int  PTR_W   = 3,
  parameter type entry_t = fb_entry_t
) (
  input  logic             clk,
  input  logic             wr_en   [FETCH_W],
  input  logic [PTR_W-1:0] wr_addr [FETCH_W],
  input  entry_t           wr_data [FETCH_W],
  input  logic [PTR_W-1:0] rd_addr [ISSUE_W],
  output entry_t           rd_data [ISSUE_W]
);

  entry_t mem [DEPTH];

  // Write accepted lanes; the top guarantees distinct addresses per cycle.
  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_W; j++) begin
      if (wr_en[j]) mem[wr_addr[j]] <= wr_data[j];
    end
  end

  // Asynchronous read of the oldest ISSUE_W slots.
  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      rd_data[i] = mem[rd_addr[i]];
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// In-order instruction queue between fetch and decode.
// Accepts up to FETCH_W {pc, inst} pairs per cycle and presents up to ISSUE_W
// oldest entries. Decode consumes 0..ISSUE_W per cycle; flush empties it.
// Optional macro FETCH_BUFFER_BYPASS_EN: when the buffer is empty, incoming
// lanes are forwarded to the outputs in the same cycle (zero latency).
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int WIDTH   = FB_WIDTH,
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [FETCH_W-1:0]           in_valid,
  output logic                         in_ready,
  input  logic [WIDTH*FETCH_W-1:0]     in_pc,
  input  logic [WIDTH*FETCH_W-1:0]     in_inst,
  output logic [ISSUE_W-1:0]           out_valid,
  output logic [WIDTH*ISSUE_W-1:0]     out_pc,
  output logic [WIDTH*ISSUE_W-1:0]     out_inst,
  input  logic [$clog2(ISSUE_W+1)-1:0] issue_take,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inst;
  } entry_t;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  int unsigned in_cnt;
  int unsigned push;
  int unsigned avail;
  int unsigned take;
  int unsigned wr_skip;
  int unsigned n_wr;
  logic        run;
  logic        byp;

  entry_t           in_ent  [FETCH_W];
  entry_t           byp_ent [ISSUE_W];
  entry_t           rd_data [ISSUE_W];
  logic [PTR_W-1:0] rd_addr [ISSUE_W];
  logic             wr_en   [FETCH_W];
  logic [PTR_W-1:0] wr_addr [FETCH_W];
  entry_t           wr_data [FETCH_W];

  // Unpack the flat input lanes into entries.
  always_comb begin
    for (int j = 0; j < FETCH_W; j++) begin
      in_ent[j].pc   = in_pc[j*WIDTH +: WIDTH];
      in_ent[j].inst = in_inst[j*WIDTH +: WIDTH];
    end
  end

  // Bypass view of the input lanes, widened/narrowed to ISSUE_W lanes.
  for (genvar g = 0; g < ISSUE_W; g++) begin : g_byp_lane
    if (g < FETCH_W) begin : g_have
      assign byp_ent[g] = in_ent[g];
    end else begin : g_none
      assign byp_ent[g] = '0;
    end
  end

  // Count consecutive valid lanes from lane 0; a gap ends the group.
  always_comb begin
    in_cnt = 0;
    run    = 1'b1;
    for (int j = 0; j < FETCH_W; j++) begin
      if (run && in_valid[j]) in_cnt = in_cnt + 1;
      else                    run    = 1'b0;
    end
  end

  // Space for a whole group, judged on the registered count only.
  assign in_ready = !rst && ((DEPTH - int'(count_q)) >= FETCH_W);
  assign push     = in_ready ? in_cnt : 0;
  assign count    = count_q;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign byp = (count_q == '0) && !flush && !rst;
`else
  assign byp = 1'b0;
`endif

  // Visible lanes and the clamped consume amount.
  always_comb begin
    avail = byp ? min_u(in_cnt, ISSUE_W) : min_u(32'(count_q), ISSUE_W);
    take  = min_u(32'(issue_take), avail);
  end

  // Drive output lanes; lanes beyond avail (or under reset) read as zero.
  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      rd_addr[i] = head_q + PTR_W'(i);
      if (!rst && (i < avail)) begin
        out_valid[i] = 1'b1;
`ifdef FETCH_BUFFER_BYPASS_EN
        out_pc[i*WIDTH +: WIDTH]   = byp ? byp_ent[i].pc   : rd_data[i].pc;
        out_inst[i*WIDTH +: WIDTH] = byp ? byp_ent[i].inst : rd_data[i].inst;
`else
        out_pc[i*WIDTH +: WIDTH]   = rd_data[i].pc;
        out_inst[i*WIDTH +: WIDTH] = rd_data[i].inst;
`endif
      end
    end
  end

  // Write accepted lanes at tail; in bypass the consumed lanes are skipped.
  always_comb begin
    wr_skip = byp ? take : 0;
    n_wr    = push - wr_skip;
    for (int j = 0; j < FETCH_W; j++) begin
      wr_en[j]   = !flush && !rst && (j < n_wr);
      wr_addr[j] = tail_q + PTR_W'(j);
      wr_data[j] = '0;
      if ((j + wr_skip) < FETCH_W) wr_data[j] = in_ent[j + wr_skip];
    end
  end

  // Next pointer/occupancy; flush discards everything incl. this cycle's push/take.
  always_comb begin
    head_d  = head_q + PTR_W'(byp ? 0 : take);
    tail_d  = tail_q + PTR_W'(n_wr);
    count_d = count_q + CNT_W'(push) - CNT_W'(take);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state register; reset has priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fetch_buffer_ram #(
    .DEPTH   (DEPTH),
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W),
    .PTR_W   (PTR_W),
    .entry_t (entry_t)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a queue scoreboard of stored PCs.
// Works with or without FETCH_BUFFER_BYPASS_EN defined.
module tb_fetch_buffer;

  localparam logic [31:0] INS_X = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_inst;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  issue_take;
  logic [3:0]  count;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [31:0] mq[$];
  logic [31:0] nxt;
  int          acc;

  always #5 clk = ~clk;

  fetch_buffer #(
    .WIDTH   (32),
    .DEPTH   (8),
    .FETCH_W (2),
    .ISSUE_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .issue_take (issue_take),
    .count      (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic step(input logic fl, input logic [1:0] iv, input logic [31:0] p0,
                      input logic [31:0] p1, input int tk, output int accepted);
    int          ic, sz, nv, t, psh;
    logic        rdy, byp;
    logic [31:0] vis [2];
    logic [31:0] lanes [2];
    flush      = fl;
    in_valid   = iv;
    in_pc      = {p1, p0};
    in_inst    = {p1 ^ INS_X, p0 ^ INS_X};
    issue_take = 2'(tk);
    lanes[0]   = p0;
    lanes[1]   = p1;
    #1;
    ic  = iv[0] ? (iv[1] ? 2 : 1) : 0;
    sz  = mq.size();
    rdy = (8 - sz) >= 2;
    psh = rdy ? ic : 0;
    byp = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
    if (sz == 0 && !fl) byp = 1'b1;
`endif
    if (byp) begin
      nv     = (ic < 2) ? ic : 2;
      vis[0] = p0;
      vis[1] = p1;
    end else begin
      nv     = (sz < 2) ? sz : 2;
      vis[0] = (sz > 0) ? mq[0] : 32'h0;
      vis[1] = (sz > 1) ? mq[1] : 32'h0;
    end
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("count", 64'(count), 64'(sz));
    for (int l = 0; l < 2; l++) begin
      check("out_valid", 64'(out_valid[l]), 64'(l < nv));
      check("out_pc", 64'(out_pc[l*32 +: 32]), 64'((l < nv) ? vis[l] : 32'h0));
    end
    check("out_inst0", 64'(out_inst[31:0]), 64'((nv > 0) ? (vis[0] ^ INS_X) : 32'h0));
    t = (tk < nv) ? tk : nv;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else if (byp) begin
      for (int k = t; k < psh; k++) mq.push_back(lanes[k]);
    end else begin
      for (int k = 0; k < t; k++) void'(mq.pop_front());
      for (int k = 0; k < psh; k++) mq.push_back(lanes[k]);
    end
    accepted = fl ? 0 : psh;
    @(negedge clk);
    flush      = 1'b0;
    in_valid   = 2'b00;
    issue_take = 2'd0;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 2'b11;
    in_pc      = {32'h1234_0004, 32'h1234_0000};
    in_inst    = 64'h0;
    issue_take = 2'd0;

    // Reset held two cycles with valid input.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
    end
    rst      = 1'b0;
    in_valid = 2'b00;
    #1;
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic push, visible one cycle later.
    step(1'b0, 2'b11, 32'h0, 32'h4, 0, acc);
    check("basic_count", 64'(count), 64'd2);
    check("basic_valid", 64'(out_valid), 64'h3);
    check("basic_lane0", 64'(out_pc[31:0]), 64'h0);
    check("basic_lane1", 64'(out_pc[63:32]), 64'h4);
    nxt = 32'h8;

    // Fill to full, then a dropped group, then drain two.
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 2'b11, nxt, nxt + 32'h4, 0, acc);
      nxt = nxt + 32'(4 * acc);
    end
    check("full_count", 64'(count), 64'd8);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b0, 2'b11, nxt, nxt + 32'h4, 0, acc);
    nxt = nxt + 32'(4 * acc);
    check("full_drop_count", 64'(count), 64'd8);
    step(1'b0, 2'b00, 32'h0, 32'h0, 2, acc);
    check("drain_count", 64'(count), 64'd6);
    check("drain_in_ready", 64'(in_ready), 64'd1);

    // Sequential PCs with random consumption across pointer wrap.
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 2'b11, nxt, nxt + 32'h4, int'($urandom_range(0, 2)), acc);
      nxt = nxt + 32'(4 * acc);
      check("count_le_depth", 64'(count <= 4'd8), 64'd1);
    end

    // Clear, build occupancy 5, then flush colliding with push and take.
    step(1'b1, 2'b00, 32'h0, 32'h0, 0, acc);
    check("flush_clear_count", 64'(count), 64'd0);
    for (int g = 0; g < 2; g++) begin
      step(1'b0, 2'b11, nxt, nxt + 32'h4, 0, acc);
      nxt = nxt + 32'(4 * acc);
    end
    step(1'b0, 2'b01, nxt, 32'hFFFF_FFF0, 0, acc);
    nxt = nxt + 32'(4 * acc);
    check("pre_flush_count", 64'(count), 64'd5);
    step(1'b1, 2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 2, acc);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 0, acc);

    // Over-request clamp and malformed valid pattern.
    step(1'b0, 2'b01, nxt, 32'hFFFF_FFF0, 0, acc);
    nxt = nxt + 32'(4 * acc);
    check("one_count", 64'(count), 64'd1);
    step(1'b0, 2'b00, 32'h0, 32'h0, 2, acc);
    check("clamp_count", 64'(count), 64'd0);
    step(1'b0, 2'b10, 32'h100, 32'h104, 0, acc);
    check("gap_count", 64'(count), 64'd0);
    check("gap_out_valid", 64'(out_valid), 64'd0);

    // Empty buffer push with a take of one.
    step(1'b0, 2'b11, 32'h40, 32'h44, 1, acc);
`ifdef FETCH_BUFFER_BYPASS_EN
    check("byp_count", 64'(count), 64'd1);
    check("byp_lane0", 64'(out_pc[31:0]), 64'h44);
`else
    check("nobyp_count", 64'(count), 64'd2);
    check("nobyp_lane0", 64'(out_pc[31:0]), 64'h40);
`endif
    step(1'b0, 2'b00, 32'h0, 32'h0, 2, acc);
    step(1'b0, 2'b00, 32'h0, 32'h0, 2, acc);
    check("final_count", 64'(count), 64'd0);

    if (failed != 0) $display("%0d comparisons did not match", failed);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
